sap1_control_sequencer: RTL
===========================

Name: sap1_control_sequencer

Overview:
- Microcoded control unit for the SAP-1 datapath: the other end of the ALU control/flag interface.
- Drives ALU control (`o_alu_sub`, `o_alu_latch_flags`) and all bus/register strobes.
- Consumes the ALU's registered flags (zero, carry, odd) to resolve conditional jumps.
- Steps a T-state counter through fetch and variable-length execute phases, advancing only on the shared `mclk_en` strobe.

Parameters:
- OPCODE_WIDTH, 4, width of the opcode field from the instruction register.
- STEP_WIDTH, 3, width of the T-state counter; must hold steps 0..4.

Ports:
- mclk  input  1  system clock; the only clock.
- i_rst  input  1  synchronous, active-high reset.
- mclk_en  input  1  clock enable; all state advances only on mclk edges where this is 1.
- i_opcode  input  OPCODE_WIDTH  opcode from the instruction register.
- i_zero  input  1  ALU zero flag (registered in ALU).
- i_carry  input  1  ALU carry flag.
- i_odd  input  1  ALU odd flag.
- o_pc_out / o_pc_inc / o_pc_load  output  1 each  program counter strobes.
- o_mar_in  output  1  memory address register load.
- o_ram_in / o_ram_out  output  1 each  RAM write / drive bus.
- o_ir_in / o_ir_out  output  1 each  instruction register load / drive operand onto bus.
- o_a_in / o_a_out / o_b_in  output  1 each  A and B register strobes.
- o_alu_out  output  1  ALU result onto bus.
- o_alu_sub  output  1  ALU subtract select.
- o_alu_latch_flags  output  1  ALU flag latch enable.
- o_out_in  output  1  output register load.
- o_halt  output  1  processor halted.
- o_step  output  STEP_WIDTH  current T-state, for debug and display.

Behaviour:
- State: step counter `step` (0..4) and a sticky `halted` bit, both registered.
- All outputs are combinational from `step`, `halted`, `i_opcode` and the flags.

Reset:
- When `i_rst` is 1 on a mclk edge (regardless of `mclk_en`): `step`=0, `halted`=0.
- While `i_rst` is high, every control output is forced to 0, including `o_halt`; `o_step` reads 0.

Advance rule:
- On a mclk edge with `mclk_en`=1 and not halted: `step` goes to 0 if the current step is the last step of the instruction, otherwise `step`+1.
- When `mclk_en`=0, state holds and outputs are stable.

Fetch phase:
- T0: `o_pc_out`, `o_mar_in`.
- T1: `o_ram_out`, `o_ir_in`, `o_pc_inc`.

Execute phase (T2 onward), by opcode:
- NOP 0000: no execute steps; the last step is T1.
- LDA 0001: T2 `ir_out`, `mar_in`; T3 `ram_out`, `a_in` (last).
- ADD 0010: T2 `ir_out`, `mar_in`; T3 `ram_out`, `b_in`; T4 `alu_out`, `a_in`, `alu_latch_flags` (last).
- SUB 0011: as ADD, with `o_alu_sub`=1 at T3 and T4.
- STA 0100: T2 `ir_out`, `mar_in`; T3 `a_out`, `ram_in` (last).
- LDI 0101: T2 `ir_out`, `a_in` (last).
- JMP 0110: T2 `ir_out`, `pc_load` (last).
- JC 0111 / JZ 1000 / JO 1001: T2 `ir_out`; `pc_load` only if `i_carry` / `i_zero` / `i_odd` is 1 (last). The flag is sampled combinationally during T2.
- OUT 1110: T2 `a_out`, `out_in` (last).
- HLT 1111: T2 `o_halt` (last). The enabled edge sets `halted`=1.
- Opcodes 1010–1101 behave as NOP.

Halted state:
- `o_halt`=1, all other strobes 0, `step` frozen at 0.
- Ignores `mclk_en` and `i_opcode`; only `i_rst` exits.

Flag timing and one-hot rule:
- Flags latched at ADD/SUB T4 are visible to a jump in the following instruction.
- The sequencer never asserts `o_alu_latch_flags` outside ADD/SUB T4.
- At most one bus driver (`pc_out`, `ram_out`, `ir_out`, `a_out`, `alu_out`) is asserted in any state.

Simultaneous events:
- `i_rst` beats `mclk_en` and halt.
- A reset mid-instruction discards the instruction; the next fetch starts at T0.

Decomposition:
- Shared package `sap1_pkg` holds:
  - opcode localparams (OP_NOP..OP_HLT);
  - step constants T0..T4;
  - a control-word struct/bit-index constants shared with the datapath top level.
- Sub-module `sap1_microcode`: purely combinational decode of `step`, `i_opcode` and flags into the control word plus a `last_step` bit.
- The sequencer top holds only the counter, the halt register and the reset gating.

Test Plan:
- Reset: hold `i_rst`=1 for 2 edges with `mclk_en`=1 → all outputs 0, `o_step`=0. After release → `o_pc_out`=`o_mar_in`=1, all other strobes 0.
- ADD (0010), `mclk_en`=1 every cycle:
  - `o_step` sequence is 0,1,2,3,4,0.
  - `o_alu_latch_flags`=1 only at step 4.
  - `o_alu_sub`=0 throughout; the bus-driver one-hot check holds every cycle.
- JC (0111): with `i_carry`=1 → `o_pc_load`=1 at step 2. With `i_carry`=0 → `o_pc_load`=0. Both return to step 0 on the next enabled edge.
- Clock enable: `mclk_en` high 1 cycle in 3 with LDA (0001) → `o_step` changes only on enabled edges; the instruction completes after exactly 4 enabled edges.
- Halt: HLT (1111) → `o_halt`=1 from the edge after T2. It stays 1 for 20 cycles while opcode and `mclk_en` toggle; `i_rst` clears it to 0.
- Reset mid-instruction: assert `i_rst` at step 3 of SUB → next cycle `o_step`=0, `o_alu_latch_flags` never asserted, and the fetch restarts cleanly.

Source files
------------

// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: opcodes, T-state encoding and the control word
// that the sequencer hands to the datapath top level.
package sap1_pkg;

    localparam int OPCODE_WIDTH = 4;
    localparam int STEP_WIDTH   = 3;

    localparam logic [OPCODE_WIDTH-1:0] OP_NOP = 4'h0;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDA = 4'h1;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = 4'h2;
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = 4'h3;
    localparam logic [OPCODE_WIDTH-1:0] OP_STA = 4'h4;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDI = 4'h5;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = 4'h6;
    localparam logic [OPCODE_WIDTH-1:0] OP_JC  = 4'h7;
    localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = 4'h8;
    localparam logic [OPCODE_WIDTH-1:0] OP_JO  = 4'h9;
    localparam logic [OPCODE_WIDTH-1:0] OP_OUT = 4'hE;
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = 4'hF;

    typedef enum logic [STEP_WIDTH-1:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    // Field order is the bit order the datapath top level slices on.
    typedef struct packed {
        logic pc_out;
        logic pc_inc;
        logic pc_load;
        logic mar_in;
        logic ram_in;
        logic ram_out;
        logic ir_in;
        logic ir_out;
        logic a_in;
        logic a_out;
        logic b_in;
        logic alu_out;
        logic alu_sub;
        logic alu_latch_flags;
        logic out_in;
        logic halt;
    } ctrl_word_t;

    localparam int CW_WIDTH = $bits(ctrl_word_t);

endpackage

// File: rtl/sap1_microcode.sv
// Combinational microcode ROM: maps (step, opcode, flags) to a control word
// and flags the final T-state of the current instruction.
module sap1_microcode
    import sap1_pkg::*;
#(
    parameter int OPCODE_WIDTH = sap1_pkg::OPCODE_WIDTH
) (
    input  step_t                   step,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    zero,
    input  logic                    carry,
    input  logic                    odd,
    output ctrl_word_t              cw,
    output logic                    last_step
);

    always_comb begin
        cw        = '0;
        last_step = 1'b0;
        case (step)
            T0: begin
                cw.pc_out = 1'b1;
                cw.mar_in = 1'b1;
            end
            T1: begin
                cw.ram_out = 1'b1;
                cw.ir_in   = 1'b1;
                cw.pc_inc  = 1'b1;
                last_step  = !(opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
                                              OP_JMP, OP_JC, OP_JZ, OP_JO, OP_OUT, OP_HLT});
            end
            T2: begin
                last_step = 1'b1;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw.ir_out = 1'b1;
                        cw.mar_in = 1'b1;
                        last_step = 1'b0;
                    end
                    OP_LDI: begin
                        cw.ir_out = 1'b1;
                        cw.a_in   = 1'b1;
                    end
                    OP_JMP: begin
                        cw.ir_out  = 1'b1;
                        cw.pc_load = 1'b1;
                    end
                    OP_JC: begin
                        cw.ir_out  = 1'b1;
                        cw.pc_load = carry;
                    end
                    OP_JZ: begin
                        cw.ir_out  = 1'b1;
                        cw.pc_load = zero;
                    end
                    OP_JO: begin
                        cw.ir_out  = 1'b1;
                        cw.pc_load = odd;
                    end
                    OP_OUT: begin
                        cw.a_out  = 1'b1;
                        cw.out_in = 1'b1;
                    end
                    OP_HLT: cw.halt = 1'b1;
                    default: ;
                endcase
            end
            T3: begin
                last_step = 1'b1;
                case (opcode)
                    OP_LDA: begin
                        cw.ram_out = 1'b1;
                        cw.a_in    = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw.ram_out = 1'b1;
                        cw.b_in    = 1'b1;
                        cw.alu_sub = (opcode == OP_SUB);
                        last_step  = 1'b0;
                    end
                    OP_STA: begin
                        cw.a_out  = 1'b1;
                        cw.ram_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                last_step = 1'b1;
                if (opcode == OP_ADD || opcode == OP_SUB) begin
                    cw.alu_out         = 1'b1;
                    cw.a_in            = 1'b1;
                    cw.alu_latch_flags = 1'b1;
                    cw.alu_sub         = (opcode == OP_SUB);
                end
            end
            // Unreachable encodings fall back to a fresh fetch.
            default: last_step = 1'b1;
        endcase
    end

endmodule

// File: rtl/sap1_control_sequencer.sv
// SAP-1 control sequencer: T-state counter, sticky halt and reset gating
// around the microcode decode.
module sap1_control_sequencer
    import sap1_pkg::*;
#(
    parameter int OPCODE_WIDTH = sap1_pkg::OPCODE_WIDTH,
    parameter int STEP_WIDTH   = sap1_pkg::STEP_WIDTH
) (
    input  logic                    mclk,
    input  logic                    i_rst,
    input  logic                    mclk_en,
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    input  logic                    i_zero,
    input  logic                    i_carry,
    input  logic                    i_odd,
    output logic                    o_pc_out,
    output logic                    o_pc_inc,
    output logic                    o_pc_load,
    output logic                    o_mar_in,
    output logic                    o_ram_in,
    output logic                    o_ram_out,
    output logic                    o_ir_in,
    output logic                    o_ir_out,
    output logic                    o_a_in,
    output logic                    o_a_out,
    output logic                    o_b_in,
    output logic                    o_alu_out,
    output logic                    o_alu_sub,
    output logic                    o_alu_latch_flags,
    output logic                    o_out_in,
    output logic                    o_halt,
    output logic [STEP_WIDTH-1:0]   o_step
);

    step_t      step, step_next;
    logic       halted, halted_next;
    ctrl_word_t cw, cw_out;
    logic       last_step;

    sap1_microcode #(
        .OPCODE_WIDTH(OPCODE_WIDTH)
    ) u_microcode (
        .step      (step),
        .opcode    (i_opcode),
        .zero      (i_zero),
        .carry     (i_carry),
        .odd       (i_odd),
        .cw        (cw),
        .last_step (last_step)
    );

    always_ff @(posedge mclk) begin
        if (i_rst) begin
            step   <= T0;
            halted <= 1'b0;
        end else begin
            step   <= step_next;
            halted <= halted_next;
        end
    end

    always_comb begin
        step_next   = step;
        halted_next = halted;
        if (mclk_en && !halted) begin
            step_next = last_step ? T0 : step_t'(3'(step) + 3'd1);
            if (cw.halt) begin
                halted_next = 1'b1;
            end
        end
    end

    // Reset silences everything; once halted only the halt line stays up.
    always_comb begin
        cw_out = cw;
        if (i_rst || halted) begin
            cw_out = '0;
        end
        cw_out.halt = !i_rst && (halted || cw.halt);
    end

    assign o_pc_out          = cw_out.pc_out;
    assign o_pc_inc          = cw_out.pc_inc;
    assign o_pc_load         = cw_out.pc_load;
    assign o_mar_in          = cw_out.mar_in;
    assign o_ram_in          = cw_out.ram_in;
    assign o_ram_out         = cw_out.ram_out;
    assign o_ir_in           = cw_out.ir_in;
    assign o_ir_out          = cw_out.ir_out;
    assign o_a_in            = cw_out.a_in;
    assign o_a_out           = cw_out.a_out;
    assign o_b_in            = cw_out.b_in;
    assign o_alu_out         = cw_out.alu_out;
    assign o_alu_sub         = cw_out.alu_sub;
    assign o_alu_latch_flags = cw_out.alu_latch_flags;
    assign o_out_in          = cw_out.out_in;
    assign o_halt            = cw_out.halt;
    assign o_step            = i_rst ? '0 : STEP_WIDTH'(step);

endmodule
